// File: rtl/display_route_arbiter_if.sv
// ---------------------------------------------------------------------------
// display_route_arbiter_if
//
// Purpose:
//   Bundles the requester handshakes and the demux drive signals of the
//   display route arbiter into one interface.
//
// Signals (N = data width):
//   req0_i / req1_i       request from bank 0 / bank 1 writer
//   data0_i / data1_i     N-bit data from bank 0 / bank 1 writer
//   ack0_o / ack1_o       one-cycle completion pulse to each requester
//   selection_o           demux select (0 = bank 0, 1 = bank 1)
//   data_o                N-bit demux data input
//   strobe_o              high on the first drive cycle of a grant
//   busy_o                high while a transaction is in progress
//
// Modports:
//   master  requester side (drives requests and data)
//   slave   arbiter side (drives acks and demux signals)
// ---------------------------------------------------------------------------
interface display_route_arbiter_if #(
  parameter int N = 8
);

  logic         req0_i;
  logic [N-1:0] data0_i;
  logic         ack0_o;
  logic         req1_i;
  logic [N-1:0] data1_i;
  logic         ack1_o;
  logic         selection_o;
  logic [N-1:0] data_o;
  logic         strobe_o;
  logic         busy_o;

  modport master (
    output req0_i, data0_i, req1_i, data1_i,
    input  ack0_o, ack1_o, selection_o, data_o, strobe_o, busy_o
  );

  modport slave (
    input  req0_i, data0_i, req1_i, data1_i,
    output ack0_o, ack1_o, selection_o, data_o, strobe_o, busy_o
  );

endinterface

// File: rtl/display_route_arbiter.sv
// ---------------------------------------------------------------------------
// display_route_arbiter
//
// Purpose:
//   Shares the 1-to-2 display routing demux between the bank 0 and bank 1
//   writers. A grant latches the winner's data, drives select/data for HOLD
//   cycles, blanks the data for one cycle while acknowledging the winner,
//   then spends one mandatory idle cycle before the next grant.
//
// Parameters:
//   N     data width (matches the demux data width)
//   HOLD  cycles select/data are driven per grant (HOLD >= 1)
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    display_route_arbiter_if slave modport (requests, acks, demux)
// ---------------------------------------------------------------------------
module display_route_arbiter #(
  parameter int N    = 8,
  parameter int HOLD = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  display_route_arbiter_if.slave  bus
);

  // A one-bit counter is kept even when HOLD=1 so the compare stays legal.
  localparam int            CW       = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic [N-1:0]  data_q, data_d;
  logic          strobe_q, strobe_d;
  logic          busy_q, busy_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_grant_q, last_grant_d;
  logic          grant;

  // State and output registers. last_grant resets to 1 so that requester 0
  // wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      data_q       <= '0;
      strobe_q     <= 1'b0;
      busy_q       <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      data_q       <= data_d;
      strobe_q     <= strobe_d;
      busy_q       <= busy_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state and next-output logic. Every output is computed one cycle
  // ahead so that the registered value matches the state being entered.
  // strobe and the acks default low so they can only ever be one-cycle pulses.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    data_d       = data_q;
    strobe_d     = 1'b0;
    busy_d       = busy_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant        = 1'b0;

    case (state_q)
      IDLE: begin
        data_d = '0;
        busy_d = 1'b0;
        if (bus.req0_i || bus.req1_i) begin
          // On a tie the requester that did not win last time is served.
          grant        = (bus.req0_i && bus.req1_i) ? ~last_grant_q : bus.req1_i;
          state_d      = DRIVE;
          sel_d        = grant;
          data_d       = grant ? bus.data1_i : bus.data0_i;
          last_grant_d = grant;
          cnt_d        = '0;
          strobe_d     = 1'b1;
          busy_d       = 1'b1;
        end
      end

      DRIVE: begin
        busy_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Blank the data during the gap so the demux output never ghosts
          // into the next grant; the grantee is acknowledged here.
          state_d = GAP;
          data_d  = '0;
          ack0_d  = ~sel_q;
          ack1_d  = sel_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      GAP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        data_d  = '0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        data_d  = '0;
      end
    endcase
  end

  assign bus.selection_o = sel_q;
  assign bus.data_o      = data_q;
  assign bus.strobe_o    = strobe_q;
  assign bus.busy_o      = busy_q;
  assign bus.ack0_o      = ack0_q;
  assign bus.ack1_o      = ack1_q;

endmodule

// File: tb/tb_display_route_arbiter.sv
// ---------------------------------------------------------------------------
// tb_display_route_arbiter
//
// Purpose:
//   Self-checking bench for display_route_arbiter. A transaction-level
//   reference model decides from the arbitration rules when and to whom each
//   grant happens and queues the expected grant; a separate monitor compares
//   every cycle of the DUT against the queued grant. A second instance with
//   HOLD=1 is exercised with both requesters held high.
// ---------------------------------------------------------------------------
module tb_display_route_arbiter;

  localparam int N    = 8;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst_n;

  display_route_arbiter_if #(.N(N)) bus ();
  display_route_arbiter_if #(.N(N)) bus1 ();

  display_route_arbiter #(.N(N), .HOLD(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  display_route_arbiter #(.N(N), .HOLD(1)) dut_h1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         who;
    logic [N-1:0] data;
    int           cycle;
  } txn_t;

  txn_t exp_q[$];
  int   cyc;
  int   checks;
  int   errors;

  // Common comparison: counts every check and reports any difference.
  task automatic check_output(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at cycle %0d",
               name, actual, expected, cyc);
    end
  endtask

  function automatic logic [15:0] pack(input logic sel, input logic [N-1:0] d,
                                       input logic stb, input logic bsy,
                                       input logic a0, input logic a1);
    return {3'b000, sel, d, stb, bsy, a0, a1};
  endfunction

  function automatic logic [15:0] main_outs();
    return pack(bus.selection_o, bus.data_o, bus.strobe_o, bus.busy_o,
                bus.ack0_o, bus.ack1_o);
  endfunction

  function automatic logic [15:0] h1_outs();
    return pack(bus1.selection_o, bus1.data_o, bus1.strobe_o, bus1.busy_o,
                bus1.ack0_o, bus1.ack1_o);
  endfunction

  // Reference model: an arbiter that becomes free HOLD+2 cycles after each
  // grant, serves a lone requester, and alternates on ties. Each grant is
  // queued with the cycle on which its strobe must be visible.
  txn_t model_txn;
  initial begin : ref_model
    int   free_at;
    logic last;
    logic r0, r1;
    cyc     = 0;
    free_at = 0;
    last    = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        free_at = 0;
        last    = 1'b1;
        exp_q.delete();
      end else begin
        r0 = bus.req0_i;
        r1 = bus.req1_i;
        if (cyc >= free_at && (r0 || r1)) begin
          model_txn.who   = (r0 && r1) ? ~last : r1;
          model_txn.data  = model_txn.who ? bus.data1_i : bus.data0_i;
          model_txn.cycle = cyc;
          exp_q.push_back(model_txn);
          last    = model_txn.who;
          free_at = cyc + HOLD + 2;
        end
      end
    end
  end

  // Monitor: on each strobe pops the expected grant, then follows it through
  // HOLD drive cycles, the gap with its ack, and the mandatory idle cycle.
  txn_t mon_cur;
  initial begin : monitor
    int phase;
    bit in_txn;
    in_txn = 1'b0;
    phase  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check_output("reset_outputs", main_outs(), 16'h0000);
        in_txn = 1'b0;
      end else if (bus.strobe_o) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_strobe", 16'(bus.strobe_o), 16'h0000);
          in_txn = 1'b0;
        end else begin
          mon_cur = exp_q.pop_front();
          check_output("grant_cycle", 16'(cyc), 16'(mon_cur.cycle));
          check_output("grant_outputs", main_outs(),
                       pack(mon_cur.who, mon_cur.data, 1'b1, 1'b1, 1'b0, 1'b0));
          in_txn = 1'b1;
          phase  = 1;
        end
      end else if (in_txn) begin
        phase++;
        if (phase <= HOLD) begin
          check_output("drive_hold", main_outs(),
                       pack(mon_cur.who, mon_cur.data, 1'b0, 1'b1, 1'b0, 1'b0));
        end else if (phase == HOLD + 1) begin
          check_output("gap_ack", main_outs(),
                       pack(mon_cur.who, '0, 1'b0, 1'b1, ~mon_cur.who, mon_cur.who));
        end else begin
          check_output("idle_after_gap", main_outs(),
                       pack(mon_cur.who, '0, 1'b0, 1'b0, 1'b0, 1'b0));
          in_txn = 1'b0;
        end
      end else begin
        check_output("idle_quiet",
                     16'({bus.data_o, bus.busy_o, bus.ack0_o, bus.ack1_o}), 16'h0000);
      end
    end
  end

  // Raise the requests selected by mask with the given data.
  task automatic apply_stimulus(input logic [1:0] mask, input logic [N-1:0] d0,
                                input logic [N-1:0] d1);
    @(negedge clk);
    if (mask[0]) begin
      bus.data0_i = d0;
      bus.req0_i  = 1'b1;
    end
    if (mask[1]) begin
      bus.data1_i = d1;
      bus.req1_i  = 1'b1;
    end
  endtask

  // Requester behaviour: wait for the ack, then release req after the edge
  // on which the ack was sampled.
  task automatic wait_ack(input int side);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      seen = (side == 0) ? bus.ack0_o : bus.ack1_o;
    end
    check_output(side == 0 ? "ack0_seen" : "ack1_seen", 16'(seen), 16'h0001);
    @(posedge clk);
    #1;
    if (side == 0) bus.req0_i = 1'b0;
    else           bus.req1_i = 1'b0;
  endtask

  task automatic wait_strobe();
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      seen = bus.strobe_o;
    end
    check_output("strobe_seen", 16'(seen), 16'h0001);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // HOLD=1 instance with both requesters held high: DRIVE, GAP, IDLE with a
  // period of three, grants alternating starting with requester 0.
  task automatic check_hold1();
    logic [N-1:0] hd [2];
    logic [15:0]  exp_v;
    int           g;
    int           ph;
    hd[0] = 8'($urandom);
    hd[1] = 8'($urandom);
    @(negedge clk);
    bus1.data0_i = hd[0];
    bus1.data1_i = hd[1];
    bus1.req0_i  = 1'b1;
    bus1.req1_i  = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      g  = (k / 3) % 2;
      ph = k % 3;
      case (ph)
        0:       exp_v = pack(g[0], hd[g], 1'b1, 1'b1, 1'b0, 1'b0);
        1:       exp_v = pack(g[0], '0, 1'b0, 1'b1, ~g[0], g[0]);
        default: exp_v = pack(g[0], '0, 1'b0, 1'b0, 1'b0, 1'b0);
      endcase
      check_output("hold1_pattern", h1_outs(), exp_v);
    end
    @(negedge clk);
    bus1.req0_i = 1'b0;
    bus1.req1_i = 1'b0;
    wait_cycles(4);
  endtask

  // Main stimulus sequence.
  initial begin : stimulus
    logic [1:0] mask;
    int         n;
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b1;
    bus.req0_i   = 1'b0;
    bus.req1_i   = 1'b0;
    bus.data0_i  = '0;
    bus.data1_i  = '0;
    bus1.req0_i  = 1'b0;
    bus1.req1_i  = 1'b0;
    bus1.data0_i = '0;
    bus1.data1_i = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cycles(2);

    // Single request from requester 0.
    apply_stimulus(2'b01, 8'hA5, 8'h00);
    wait_ack(0);
    wait_cycles(3);

    // Requester 1 with its data changed while the grant is being driven.
    apply_stimulus(2'b10, 8'h00, 8'h3C);
    fork
      wait_ack(1);
      begin
        repeat (2) @(negedge clk);
        bus.data1_i = 8'hFF;
      end
    join
    wait_cycles(3);

    // Simultaneous requests, each held until its own ack.
    apply_stimulus(2'b11, 8'h5A, 8'hC3);
    fork
      wait_ack(0);
      wait_ack(1);
    join
    wait_cycles(3);

    // Both requesters held continuously with data churning every cycle.
    apply_stimulus(2'b11, 8'h12, 8'h34);
    repeat (4 * (HOLD + 2)) begin
      @(negedge clk);
      bus.data0_i = 8'($urandom);
      bus.data1_i = 8'($urandom);
    end
    bus.req0_i = 1'b0;
    bus.req1_i = 1'b0;
    wait_cycles(HOLD + 4);

    // Reset during the second drive cycle; the pending request restarts.
    apply_stimulus(2'b01, 8'h96, 8'h00);
    wait_strobe();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ack(0);
    wait_cycles(3);

    // Request withdrawn after one drive cycle still completes once.
    apply_stimulus(2'b01, 8'h77, 8'h00);
    wait_strobe();
    @(posedge clk);
    #1 bus.req0_i = 1'b0;
    wait_ack(0);
    wait_cycles(10);

    // Randomised request mixes with data changing mid-transaction.
    for (int i = 0; i < 30; i++) begin
      mask = 2'($urandom_range(1, 3));
      apply_stimulus(mask, 8'($urandom), 8'($urandom));
      fork
        begin
          if (mask[0]) wait_ack(0);
        end
        begin
          if (mask[1]) wait_ack(1);
        end
        begin
          repeat ($urandom_range(0, HOLD + 2)) @(negedge clk);
          bus.data0_i = 8'($urandom);
          bus.data1_i = 8'($urandom);
        end
      join
      wait_cycles($urandom_range(0, 3));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    wait_cycles(HOLD + 3);
    check_output("queue_drained", 16'(exp_q.size()), 16'h0000);

    check_hold1();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_route_arbiter.md
Name: display_route_arbiter

Overview:
- Shares the display routing demux (1-to-2, N-bit) between two requesters: display bank 0 writer and display bank 1 writer.
- Per transaction: grants one requester, latches its data, drives the demux selection and data for a fixed hold window, blanks for one cycle, then acknowledges.
- Sits in the display subsystem. Its outputs drive the demux selection and data inputs directly.

Parameters:
- N, 8, data width; equals the demux data width.
- HOLD, 4, cycles that selection/data are driven per grant (HOLD >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_i  input  1  request from requester 0; held high until ack0_o is seen.
- data0_i  input  N  data from requester 0; sampled at grant.
- ack0_o  output  1  one-cycle completion pulse to requester 0.
- req1_i  input  1  request from requester 1; same rules as req0_i.
- data1_i  input  N  data from requester 1.
- ack1_o  output  1  one-cycle completion pulse to requester 1.
- selection_o  output  1  demux select: 0 = bank 0, 1 = bank 1.
- data_o  output  N  demux data input.
- strobe_o  output  1  high on the first DRIVE cycle only.
- busy_o  output  1  high in DRIVE and GAP.

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low (rst_n). All outputs are registered.
- Reset values: state IDLE, selection_o=0, data_o=0, strobe_o=0, busy_o=0, ack0_o=0, ack1_o=0, hold counter=0, last_grant=1 (requester 0 wins the first tie).
- States:
  - IDLE: data_o=0, busy_o=0; selection_o holds its last value.
  - IDLE -> DRIVE: at a rising edge where req0_i or req1_i is high.
    - Grant: if only one requester is high, grant it. If both are high, grant the one that is not last_grant.
    - At that edge: latch the grantee's data into data_o, set selection_o = grantee index, set last_grant = grantee, clear the counter, set strobe_o=1 and busy_o=1.
  - DRIVE: lasts exactly HOLD cycles.
    - selection_o and the latched data_o are stable throughout.
    - strobe_o is high in the first DRIVE cycle only.
    - The counter increments each cycle. At the edge where counter == HOLD-1, go to GAP.
  - GAP: exactly 1 cycle.
    - data_o=0 (blanking against ghosting); selection_o still held; busy_o=1.
    - The grantee's ack is high for this cycle only. The other ack stays 0.
    - Next state: IDLE.
- Latency:
  - req sampled at an edge -> data_o valid on the next cycle.
  - A transaction occupies HOLD+1 cycles (DRIVE + GAP). The IDLE cycle after GAP is mandatory.
  - Minimum spacing between successive strobe_o pulses: HOLD+2 cycles.
- Handshake:
  - A requester keeps req high until it samples ack=1 on a clock edge. It drives req low from the next cycle.
  - Therefore req is already low in the IDLE cycle that follows GAP, and a completed request is never re-granted.
- Boundary conditions:
  - data*_i changes during DRIVE/GAP: ignored; the value was latched at grant.
  - req dropped before ack: the transaction still completes and ack is still pulsed.
  - Requests arriving during DRIVE/GAP wait. The loser of a tie waits and is granted next if it is still requesting.
  - Both requesters continuously high: grants alternate 0,1,0,1 starting with 0 after reset.
  - HOLD=1: DRIVE is one cycle and strobe_o coincides with it.
  - rst_n asserted mid-transaction: immediate return to reset values. No ack is issued for the aborted grant.

Test Plan:
- Reset, then req0_i=1 with data0_i=8'hA5, HOLD=4 -> next cycle selection_o=0, data_o=A5, strobe_o=1 for 1 cycle. data_o=A5 for 4 cycles. Then data_o=00 and ack0_o=1 for 1 cycle, then IDLE.
- req1_i=1 with data1_i=8'h3C, and data1_i changed to 8'hFF during DRIVE -> selection_o=1, data_o=3C for all 4 cycles, then ack1_o pulse.
- req0_i and req1_i both raised in the same cycle and held until each is acked -> requester 0 is served first, then requester 1. Strobes are exactly 6 cycles apart. Subsequent ties alternate 0,1,0,1.
- rst_n pulsed low during the 2nd DRIVE cycle -> outputs are 0 immediately, with no ack. After release, the pending req0_i is re-granted from scratch.
- req0_i dropped after 1 DRIVE cycle -> the transaction still runs 4 DRIVE cycles, ack0_o pulses once, and no second grant follows.
- HOLD=1, both requesters continuously high -> pattern DRIVE, GAP, IDLE repeating with period 3. Selection alternates each grant. Each ack pulses once per grant.
